// File: rtl/hm01b0_block_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : hm01b0_block_reader_if
//  Description : Signal bundle between the HM01B0 block reader, the strip
//                EBR banks and the downstream pixel consumer.
//                master : the block reader (issues EBR reads, sources pixels)
//                slave  : the environment (ingester bank flag, EBR read data,
//                         downstream ready)
//  Ports       : frontbuffer_select   bank currently being written
//                read_bank            EBR bank being read
//                read_block_select    EBR index within read_bank
//                read_addr            {row[2:0], blk[2:0], col[2:0]}
//                read_en              read strobe, data valid one cycle later
//                read_data            unsigned pixel from selected EBR
//                pix_out / pix_valid / pix_ready   level-shifted pixel stream
//                block_start          first pixel of each 8x8 block
//                strip_done           pulse after last pixel of a strip
//                overrun              sticky strip-overrun flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface hm01b0_block_reader_if;
    logic       frontbuffer_select;
    logic       read_bank;
    logic [2:0] read_block_select;
    logic [8:0] read_addr;
    logic       read_en;
    logic [7:0] read_data;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       pix_ready;
    logic       block_start;
    logic       strip_done;
    logic       overrun;

    modport master (
        input  frontbuffer_select,
        input  read_data,
        input  pix_ready,
        output read_bank,
        output read_block_select,
        output read_addr,
        output read_en,
        output pix_out,
        output pix_valid,
        output block_start,
        output strip_done,
        output overrun
    );

    modport slave (
        output frontbuffer_select,
        output read_data,
        output pix_ready,
        input  read_bank,
        input  read_block_select,
        input  read_addr,
        input  read_en,
        input  pix_out,
        input  pix_valid,
        input  block_start,
        input  strip_done,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/hm01b0_block_reader.sv
`default_nettype none
// ============================================================================
//  Module      : hm01b0_block_reader
//  Description : Reads a completed 8-row strip out of the EBR bank that the
//                ingester has just released, in 8x8 block order (row-major
//                inside each block), and streams the pixels level-shifted to
//                signed through a 2-entry output FIFO with valid/ready flow
//                control.
//  Ports       : clock   system clock
//                nreset  asynchronous active-low reset
//                bus     hm01b0_block_reader_if.master (read port + pixel
//                        stream + status, see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module hm01b0_block_reader #(
    parameter int NUM_EBRS       = 5,
    parameter int BLOCKS_PER_EBR = 8
) (
    input  wire logic               clock,
    input  wire logic               nreset,
    hm01b0_block_reader_if.master   bus
);

    localparam logic [2:0] c_last_ebr = 3'(NUM_EBRS - 1);
    localparam logic [2:0] c_last_blk = 3'(BLOCKS_PER_EBR - 1);
    localparam logic [2:0] c_last_rc  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t     r_state;

    // Bank hand-over tracking
    logic       r_fb_prev;
    logic       r_fb_armed;
    logic       r_pending;
    logic       r_next_bank;
    logic       r_overrun;

    // Read address generator
    logic       r_read_bank;
    logic [2:0] r_ebr;
    logic [2:0] r_blk;
    logic [2:0] r_row;
    logic [2:0] r_col;

    // Read issued last cycle; its tags travel alongside the returning data
    logic       r_inflight;
    logic       r_inflight_first;
    logic       r_inflight_last;

    // 2-entry FIFO, entry 0 is the head and drives the pixel outputs
    logic [1:0] r_count;
    logic [7:0] r_e0_pix;
    logic       r_e0_bs;
    logic       r_e0_last;
    logic [7:0] r_e1_pix;
    logic       r_e1_bs;
    logic       r_e1_last;

    logic       r_strip_done;

    logic       w_toggle;
    logic       w_pop;
    logic       w_credit;
    logic       w_issue;
    logic       w_drained;
    logic       w_load;
    logic       w_first_pix;
    logic       w_last_read;
    logic [7:0] w_shifted;

    // The history register is only trusted from the first cycle after reset
    // release, so whatever level the input holds at release is never a toggle.
    assign w_toggle    = r_fb_armed && (bus.frontbuffer_select != r_fb_prev);

    assign w_pop       = (r_count != 2'd0) && bus.pix_ready;

    // A read occupies a FIFO slot from issue onwards; a same-cycle pop frees
    // one, which keeps one pixel per clock flowing through only two entries.
    assign w_credit    = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2) || w_pop;
    assign w_issue     = (r_state == ST_STREAM) && w_credit;

    assign w_drained   = !r_inflight && (r_count == 2'd0);
    assign w_load      = r_pending &&
                         ((r_state == ST_IDLE) || ((r_state == ST_DRAIN) && w_drained));

    assign w_first_pix = (r_row == 3'd0) && (r_col == 3'd0);
    assign w_last_read = (r_ebr == c_last_ebr) && (r_blk == c_last_blk) &&
                         (r_row == c_last_rc)  && (r_col == c_last_rc);

    // Subtracting 128 from an unsigned byte is just an MSB flip
    assign w_shifted   = {~bus.read_data[7], bus.read_data[6:0]};

    assign bus.read_en           = w_issue;
    assign bus.read_bank         = r_read_bank;
    assign bus.read_block_select = r_ebr;
    assign bus.read_addr         = {r_row, r_blk, r_col};
    assign bus.pix_out           = r_e0_pix;
    assign bus.pix_valid         = (r_count != 2'd0);
    assign bus.block_start       = r_e0_bs && (r_count != 2'd0);
    assign bus.strip_done        = r_strip_done;
    assign bus.overrun           = r_overrun;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state          <= ST_IDLE;
            r_fb_prev        <= 1'b0;
            r_fb_armed       <= 1'b0;
            r_pending        <= 1'b0;
            r_next_bank      <= 1'b0;
            r_overrun        <= 1'b0;
            r_read_bank      <= 1'b0;
            r_ebr            <= 3'd0;
            r_blk            <= 3'd0;
            r_row            <= 3'd0;
            r_col            <= 3'd0;
            r_inflight       <= 1'b0;
            r_inflight_first <= 1'b0;
            r_inflight_last  <= 1'b0;
            r_count          <= 2'd0;
            r_e0_pix         <= 8'd0;
            r_e0_bs          <= 1'b0;
            r_e0_last        <= 1'b0;
            r_e1_pix         <= 8'd0;
            r_e1_bs          <= 1'b0;
            r_e1_last        <= 1'b0;
            r_strip_done     <= 1'b0;
        end else begin
            r_fb_prev  <= bus.frontbuffer_select;
            r_fb_armed <= 1'b1;

            // A toggle arriving while another strip is still queued means one
            // strip will never be read. A toggle landing exactly as the queued
            // strip is being taken is a normal hand-over, not an overrun.
            if (w_toggle) begin
                r_pending   <= 1'b1;
                r_next_bank <= ~bus.frontbuffer_select;
                if (r_pending && !w_load) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_load) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_issue && w_last_read) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= r_pending ? ST_STREAM : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Address walk: col, then row, then block within EBR, then EBR.
            // Counters stop on the final address so the bus holds its value.
            if (w_load) begin
                r_read_bank <= r_next_bank;
                r_ebr       <= 3'd0;
                r_blk       <= 3'd0;
                r_row       <= 3'd0;
                r_col       <= 3'd0;
            end else if (w_issue && !w_last_read) begin
                if (r_col != c_last_rc) begin
                    r_col <= r_col + 3'd1;
                end else begin
                    r_col <= 3'd0;
                    if (r_row != c_last_rc) begin
                        r_row <= r_row + 3'd1;
                    end else begin
                        r_row <= 3'd0;
                        if (r_blk != c_last_blk) begin
                            r_blk <= r_blk + 3'd1;
                        end else begin
                            r_blk <= 3'd0;
                            r_ebr <= r_ebr + 3'd1;
                        end
                    end
                end
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_first <= w_first_pix;
                r_inflight_last  <= w_last_read;
            end

            // read_data belongs to the read issued last cycle (r_inflight)
            case ({w_pop, r_inflight})
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_e0_pix  <= w_shifted;
                        r_e0_bs   <= r_inflight_first;
                        r_e0_last <= r_inflight_last;
                    end else begin
                        r_e1_pix  <= w_shifted;
                        r_e1_bs   <= r_inflight_first;
                        r_e1_last <= r_inflight_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b10: begin
                    r_e0_pix  <= r_e1_pix;
                    r_e0_bs   <= r_e1_bs;
                    r_e0_last <= r_e1_last;
                    r_count   <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_e0_pix  <= w_shifted;
                        r_e0_bs   <= r_inflight_first;
                        r_e0_last <= r_inflight_last;
                    end else begin
                        r_e0_pix  <= r_e1_pix;
                        r_e0_bs   <= r_e1_bs;
                        r_e0_last <= r_e1_last;
                        r_e1_pix  <= w_shifted;
                        r_e1_bs   <= r_inflight_first;
                        r_e1_last <= r_inflight_last;
                    end
                end
                default: begin
                end
            endcase

            r_strip_done <= w_pop && r_e0_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hm01b0_block_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hm01b0_block_reader
//  Description : Directed self-checking bench for hm01b0_block_reader with a
//                two-bank EBR model (one-cycle read latency).
//                Bank 0, EBR k holds (addr ^ k); bank 1 holds (addr ^ k ^ 0xA5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hm01b0_block_reader;

    localparam int c_npix = 2560;

    logic clock  = 1'b0;
    logic nreset = 1'b0;

    hm01b0_block_reader_if bus ();

    hm01b0_block_reader #(
        .NUM_EBRS       (5),
        .BLOCKS_PER_EBR (8)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [2][5][512];

    always @(posedge clock) begin
        if (bus.read_en) begin
            bus.read_data <= mem[bus.read_bank][bus.read_block_select][bus.read_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    // Results recorded by the strip collector
    logic [7:0] got_pix [c_npix];
    bit         got_bs  [c_npix];
    int n_pix, n_bs, n_done, bank_bad, glitches;
    int first_rd, first_val, last_xfer, done_cyc;
    logic ovr_pre;

    // Expected pixel i of a strip: block b = i/64 walks EBR-major, each block
    // row-major; EBR content is address ^ ebr (bank 1 additionally ^ 0xA5).
    function automatic logic [7:0] exp_pix(input bit bank, input int i);
        int b, ebr, blk, row, col;
        logic [8:0] a;
        logic [7:0] d;
        b   = i / 64;
        ebr = b / 8;
        blk = b % 8;
        row = (i % 64) / 8;
        col = i % 8;
        a   = {3'(row), 3'(blk), 3'(col)};
        d   = a[7:0] ^ 8'(ebr);
        if (bank) d = d ^ 8'hA5;
        return d - 8'd128;
    endfunction

    function automatic int seq_mismatches(input bit bank, input int n);
        int m;
        m = 0;
        for (int i = 0; i < n && i < c_npix; i++) begin
            if (got_pix[i] !== exp_pix(bank, i) || got_bs[i] !== ((i % 64) == 0)) m++;
        end
        return m;
    endfunction

    function automatic logic [25:0] out_vec();
        return {bus.read_bank, bus.read_block_select, bus.read_addr, bus.read_en,
                bus.pix_out, bus.pix_valid, bus.block_start, bus.strip_done, bus.overrun};
    endfunction

    // Runs one strip cycle by cycle, recording everything the tests look at.
    // Cycle 1 is the first negedge; start_tog flips frontbuffer_select there.
    // tog_a/tog_b flip it when that many pixels have been accepted;
    // abort_at asserts reset at that pixel count and returns immediately.
    task automatic collect(input bit rnd, input bit exp_bank, input bit start_tog,
                           input int tog_a, input int tog_b, input int abort_at,
                           input int max_cyc);
        bit         prev_stall;
        logic [7:0] prev_pix;
        bit         prev_bs;
        bit         ta, tb;
        prev_stall = 0; prev_pix = 0; prev_bs = 0; ta = 0; tb = 0;
        n_pix = 0; n_bs = 0; n_done = 0; bank_bad = 0; glitches = 0;
        first_rd = -1; first_val = -1; last_xfer = -1; done_cyc = -1; ovr_pre = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clock);
            bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (start_tog && cyc == 1) bus.frontbuffer_select = ~bus.frontbuffer_select;
            if (!ta && n_pix == tog_a) begin
                ta = 1;
                bus.frontbuffer_select = ~bus.frontbuffer_select;
            end
            if (!tb && n_pix == tog_b) begin
                tb = 1;
                ovr_pre = bus.overrun;
                bus.frontbuffer_select = ~bus.frontbuffer_select;
            end
            if (n_pix == abort_at) begin
                nreset = 1'b0;
                return;
            end
            #1;
            if (bus.read_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (bus.read_bank !== exp_bank) bank_bad++;
            end
            if (bus.pix_valid && first_val < 0) first_val = cyc;
            if (prev_stall && (!bus.pix_valid || bus.pix_out !== prev_pix ||
                               bus.block_start !== prev_bs)) glitches++;
            if (bus.pix_valid && bus.pix_ready) begin
                if (n_pix < c_npix) begin
                    got_pix[n_pix] = bus.pix_out;
                    got_bs[n_pix]  = bus.block_start;
                end
                if (bus.block_start) n_bs++;
                n_pix++;
                last_xfer = cyc;
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_pix   = bus.pix_out;
            prev_bs    = bus.block_start;
            if (bus.strip_done) begin
                n_done++;
                done_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        nreset = 1'b0;
        bus.frontbuffer_select = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        int act;
        nreset = 1'b0;
        bus.frontbuffer_select = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (out_vec() !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", out_vec());
        end
        @(negedge clock);
        nreset = 1'b1;
        act = 0;
        repeat (8) begin
            @(negedge clock);
            #1;
            if (bus.read_en || bus.pix_valid || bus.strip_done) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL release_idle: got %0d active cycles expected 0", act);
        end
    endtask

    task automatic test_stream();
        int extra;
        int m;
        collect(1'b0, 1'b0, 1'b1, -1, -1, -1, 4000);
        total++;
        if (n_done !== 1) begin bad++; $display("FAIL stream_done: got %0d expected 1", n_done); end
        total++;
        if (n_pix !== c_npix) begin bad++; $display("FAIL stream_count: got %0d expected %0d", n_pix, c_npix); end
        m = seq_mismatches(1'b0, c_npix);
        total++;
        if (m !== 0) begin bad++; $display("FAIL stream_seq: got %0d mismatches expected 0", m); end
        total++;
        if (got_pix[0] !== 8'h80 || got_bs[0] !== 1'b1) begin
            bad++; $display("FAIL first_pixel: got %h bs=%0d expected 80 bs=1", got_pix[0], got_bs[0]);
        end
        total++;
        if (got_pix[8] !== 8'hC0) begin bad++; $display("FAIL ninth_pixel: got %h expected c0", got_pix[8]); end
        total++;
        if (n_bs !== 40) begin bad++; $display("FAIL block_starts: got %0d expected 40", n_bs); end
        total++;
        if (first_rd !== 3) begin bad++; $display("FAIL read_latency: got %0d expected 3", first_rd); end
        total++;
        if (first_val !== 5) begin bad++; $display("FAIL valid_latency: got %0d expected 5", first_val); end
        total++;
        if (last_xfer - first_val !== c_npix - 1) begin
            bad++; $display("FAIL contiguous: got span %0d expected %0d", last_xfer - first_val, c_npix - 1);
        end
        total++;
        if (bank_bad !== 0) begin bad++; $display("FAIL stream_bank: got %0d wrong-bank reads expected 0", bank_bad); end
        total++;
        if (done_cyc !== last_xfer + 1) begin
            bad++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_xfer + 1);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clock);
            #1;
            if (bus.strip_done || bus.read_en || bus.pix_valid) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL after_strip_idle: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_backpressure();
        int m;
        reset_pulse();
        collect(1'b1, 1'b0, 1'b1, -1, -1, -1, 20000);
        bus.pix_ready = 1'b1;
        total++;
        if (n_pix !== c_npix) begin bad++; $display("FAIL bp_count: got %0d expected %0d", n_pix, c_npix); end
        m = seq_mismatches(1'b0, c_npix);
        total++;
        if (m !== 0) begin bad++; $display("FAIL bp_seq: got %0d mismatches expected 0", m); end
        total++;
        if (glitches !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d glitches expected 0", glitches); end
        total++;
        if (n_done !== 1 || done_cyc !== last_xfer + 1) begin
            bad++; $display("FAIL bp_done: got done=%0d at %0d expected 1 at %0d", n_done, done_cyc, last_xfer + 1);
        end
        total++;
        if (n_bs !== 40) begin bad++; $display("FAIL bp_block_starts: got %0d expected 40", n_bs); end
    endtask

    task automatic test_overrun();
        int m;
        int act;
        // frontbuffer_select is 1 here: first strip is bank 1; toggles at
        // pixels 100 and 110 leave it at 0, so the follow-on strip is bank 1.
        collect(1'b0, 1'b1, 1'b1, 100, 110, -1, 4000);
        total++;
        if (ovr_pre !== 1'b0 || bus.overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_flag: got before=%0d after=%0d expected 0/1", ovr_pre, bus.overrun);
        end
        m = seq_mismatches(1'b1, c_npix);
        total++;
        if (n_pix !== c_npix || n_done !== 1 || m !== 0) begin
            bad++; $display("FAIL ovr_first_strip: got n=%0d done=%0d mis=%0d expected %0d/1/0", n_pix, n_done, m, c_npix);
        end
        collect(1'b0, 1'b1, 1'b0, -1, -1, -1, 4000);
        m = seq_mismatches(1'b1, c_npix);
        total++;
        if (n_pix !== c_npix || n_done !== 1 || m !== 0 || bank_bad !== 0) begin
            bad++; $display("FAIL ovr_second_strip: got n=%0d done=%0d mis=%0d bank_bad=%0d expected %0d/1/0/0",
                            n_pix, n_done, m, bank_bad, c_npix);
        end
        act = 0;
        repeat (10) begin
            @(negedge clock);
            #1;
            if (bus.read_en || bus.pix_valid) act++;
        end
        total++;
        if (act !== 0 || bus.overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_no_third: got active=%0d overrun=%0d expected 0/1", act, bus.overrun);
        end
    endtask

    task automatic test_toggle_before_done();
        int  k;
        bit  found;
        logic bank_at;
        reset_pulse();
        total++;
        if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_cleared: got %0d expected 0", bus.overrun); end
        collect(1'b0, 1'b0, 1'b1, -1, c_npix - 1, -1, 4000);
        total++;
        if (n_pix !== c_npix || n_done !== 1) begin
            bad++; $display("FAIL late_tog_strip: got n=%0d done=%0d expected %0d/1", n_pix, n_done, c_npix);
        end
        found = 0;
        bank_at = 1'b0;
        k = 0;
        while (!found && k < 2) begin
            @(negedge clock);
            #1;
            k++;
            if (bus.read_en) begin
                found = 1;
                bank_at = bus.read_bank;
            end
        end
        total++;
        if (!found || bank_at !== 1'b1) begin
            bad++; $display("FAIL late_tog_restart: got found=%0d bank=%0d expected 1/1", found, bank_at);
        end
        total++;
        if (bus.overrun !== 1'b0) begin bad++; $display("FAIL late_tog_overrun: got %0d expected 0", bus.overrun); end
    endtask

    task automatic test_reset_midstrip();
        int m;
        int nz;
        int act;
        // Continues the bank-1 strip started at the end of the previous test
        collect(1'b0, 1'b1, 1'b0, -1, -1, 1000, 4000);
        #1;
        total++;
        if (out_vec() !== 26'd0) begin
            bad++; $display("FAIL midstrip_reset_outputs: got %h expected 0", out_vec());
        end
        m = seq_mismatches(1'b1, 1000);
        total++;
        if (n_pix !== 1000 || n_done !== 0 || m !== 0) begin
            bad++; $display("FAIL midstrip_prefix: got n=%0d done=%0d mis=%0d expected 1000/0/0", n_pix, n_done, m);
        end
        nz = 0;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (out_vec() !== 26'd0) nz++;
        end
        nreset = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clock);
            #1;
            if (bus.read_en || bus.pix_valid || bus.strip_done) act++;
        end
        total++;
        if (nz !== 0 || act !== 0) begin
            bad++; $display("FAIL midstrip_quiet: got nonzero=%0d active=%0d expected 0/0", nz, act);
        end
    endtask

    initial begin
        bus.frontbuffer_select = 1'b0;
        bus.pix_ready = 1'b1;
        for (int bk = 0; bk < 2; bk++)
            for (int k = 0; k < 5; k++)
                for (int a = 0; a < 512; a++)
                    mem[bk][k][a] = 8'(a) ^ 8'(k) ^ ((bk == 1) ? 8'hA5 : 8'h00);
        test_reset();
        test_stream();
        test_backpressure();
        test_overrun();
        test_toggle_before_done();
        test_reset_midstrip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
